// File: rtl/cpc_bus_initiator.sv
// Z80-style CPC expansion-bus cycle generator (mem rd/wr, I/O wr, M1 fetch + refresh), one clk per half T-state.
// Accept->rsp_valid: 6 clk rd/wr, 8 clk I/O and fetch, +2 per wait; cmd_ready only in IDLE or the final half-state.
module cpc_bus_initiator #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_adr,
   input  logic [7:0]  cmd_data,
   input  logic [7:0]  rfsh_hi,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_err,
   output logic        cpu_clk,
   output logic [15:0] adr,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in,
   input  logic        ready,
   output logic        mreq_b,
   output logic        iorq_b,
   output logic        rd_b,
   output logic        wr_b,
   output logic        m1_b,
   output logic        rfsh_b
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_T1H  = 4'd1;
   localparam logic [3:0] S_T1L  = 4'd2;
   localparam logic [3:0] S_T2H  = 4'd3;
   localparam logic [3:0] S_T2L  = 4'd4;
   localparam logic [3:0] S_TWH  = 4'd5;
   localparam logic [3:0] S_TWL  = 4'd6;
   localparam logic [3:0] S_T3H  = 4'd7;
   localparam logic [3:0] S_T3L  = 4'd8;
   localparam logic [3:0] S_T4H  = 4'd9;
   localparam logic [3:0] S_T4L  = 4'd10;

   localparam logic [1:0] OP_RD = 2'b00;
   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_IO = 2'b10;
   localparam logic [1:0] OP_M1 = 2'b11;

   localparam int WW = $clog2(MAX_WAIT + 1);

   logic [3:0]    state, nxt;
   logic [1:0]    op_q, nop;
   logic [WW-1:0] wcnt, nxt_wcnt;
   logic          err_q, nxt_err;
   logic [6:0]    r_cnt;
   logic [7:0]    hi_q;
   logic [7:0]    cap;
   logic          final_st, accept, rsp_fire;
   logic          n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh, n_oe, n_cpu;
   logic          act, wact, pre3;

   assign final_st  = (state == S_T3L && op_q != OP_M1) || state == S_T4L;
   assign cmd_ready = !reset && (state == S_IDLE || final_st);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      nxt      = state;
      nxt_wcnt = wcnt;
      nxt_err  = err_q;
      case (state)
         S_IDLE: nxt = S_IDLE;
         S_T1H:  nxt = S_T1L;
         S_T1L:  nxt = S_T2H;
         S_T2H:  nxt = S_T2L;
         S_T2L: begin
            // I/O always gets one TW that does not count toward the timeout
            if (op_q == OP_IO) begin
               nxt      = S_TWH;
               nxt_wcnt = '0;
            end else if (ready) begin
               nxt = S_T3H;
            end else begin
               nxt      = S_TWH;
               nxt_wcnt = WW'(1);
            end
         end
         S_TWH:  nxt = S_TWL;
         S_TWL: begin
            if (ready) begin
               nxt = S_T3H;
            end else if (wcnt == WW'(MAX_WAIT)) begin
               nxt     = S_T3H;
               nxt_err = 1'b1;
            end else begin
               nxt      = S_TWH;
               nxt_wcnt = wcnt + WW'(1);
            end
         end
         S_T3H:  nxt = S_T3L;
         S_T3L:  nxt = (op_q == OP_M1) ? S_T4H : S_IDLE;
         S_T4H:  nxt = S_T4L;
         S_T4L:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (accept) begin
         nxt      = S_T1H;
         nxt_wcnt = '0;
         nxt_err  = 1'b0;
      end
   end

   assign nop      = accept ? cmd_op : op_q;
   assign rsp_fire = (nxt == S_T3L && nop != OP_M1) || nxt == S_T4L;

   // Bus pins are decoded from the next state and registered, so they change only on clk.
   always_comb begin
      act    = nxt inside {S_T1L, S_T2H, S_T2L, S_TWH, S_TWL, S_T3H};
      wact   = nxt inside {S_T2L, S_TWH, S_TWL, S_T3H};
      pre3   = nxt inside {S_T1H, S_T1L, S_T2H, S_T2L, S_TWH, S_TWL};
      n_cpu  = nxt inside {S_T1H, S_T2H, S_TWH, S_T3H, S_T4H};
      n_mreq = 1'b1;
      n_iorq = 1'b1;
      n_rd   = 1'b1;
      n_wr   = 1'b1;
      n_m1   = 1'b1;
      n_rfsh = 1'b1;
      n_oe   = 1'b0;
      case (nop)
         OP_RD: begin
            n_mreq = !act;
            n_rd   = !act;
         end
         OP_WR: begin
            n_mreq = !act;
            n_wr   = !wact;
            n_oe   = act || nxt == S_T3L;
         end
         OP_IO: begin
            n_iorq = !(wact || nxt == S_T2H);
            n_wr   = !(wact || nxt == S_T2H);
            n_oe   = act || nxt == S_T3L;
         end
         default: begin
            n_m1   = !pre3;
            n_rd   = !(act && nxt != S_T3H);
            n_mreq = !((act && nxt != S_T3H) || nxt == S_T3L || nxt == S_T4H);
            n_rfsh = !(nxt inside {S_T3H, S_T3L, S_T4H, S_T4L});
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= OP_RD;
         wcnt      <= '0;
         err_q     <= 1'b0;
         r_cnt     <= '0;
         hi_q      <= '0;
         cap       <= '0;
         adr       <= '0;
         data_out  <= '0;
         data_oe   <= 1'b0;
         cpu_clk   <= 1'b0;
         mreq_b    <= 1'b1;
         iorq_b    <= 1'b1;
         rd_b      <= 1'b1;
         wr_b      <= 1'b1;
         m1_b      <= 1'b1;
         rfsh_b    <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else begin
         state     <= nxt;
         op_q      <= nop;
         wcnt      <= nxt_wcnt;
         err_q     <= nxt_err;
         mreq_b    <= n_mreq;
         iorq_b    <= n_iorq;
         rd_b      <= n_rd;
         wr_b      <= n_wr;
         m1_b      <= n_m1;
         rfsh_b    <= n_rfsh;
         data_oe   <= n_oe;
         cpu_clk   <= n_cpu;
         rsp_valid <= rsp_fire;
         rsp_err   <= rsp_fire && nxt_err;
         if (accept) begin
            adr  <= cmd_adr;
            hi_q <= rfsh_hi;
            if (cmd_op == OP_WR || cmd_op == OP_IO) data_out <= cmd_data;
         end else if (op_q == OP_M1 && nxt == S_T3H) begin
            // refresh uses R as it was for this fetch, then R advances (bit 7 stays 0)
            adr   <= {hi_q, 1'b0, r_cnt};
            r_cnt <= r_cnt + 7'd1;
         end
         if (state == S_T3H) cap <= data_in;
         if (state == S_T3H && op_q == OP_RD) rsp_data <= data_in;
         else if (state == S_T4H) rsp_data <= cap;
      end
   end

endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Randomized bench for cpc_bus_initiator: a per-command phase-list model predicts every bus pin each clk.
module tb_cpc_bus_initiator;

   localparam int MAX_WAIT = 15;
   localparam logic [1:0] OP_RD = 2'b00;
   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_IO = 2'b10;
   localparam logic [1:0] OP_M1 = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [15:0] cmd_adr = 16'h0000;
   logic [7:0]  cmd_data = 8'h00;
   logic [7:0]  rfsh_hi = 8'h00;
   logic        rsp_valid, rsp_err, cpu_clk, data_oe;
   logic [7:0]  rsp_data, data_out;
   logic [7:0]  data_in = 8'h00;
   logic [15:0] adr;
   logic        ready = 1'b1;
   logic        mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b;

   always #5 clk = ~clk;

   cpc_bus_initiator #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_adr(cmd_adr), .cmd_data(cmd_data), .rfsh_hi(rfsh_hi),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .cpu_clk(cpu_clk),
      .adr(adr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in), .ready(ready),
      .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b), .m1_b(m1_b), .rfsh_b(rfsh_b)
   );

   typedef enum int {P_IDLE, P_T1H, P_T1L, P_T2H, P_T2L, P_TWH, P_TWL, P_T3H, P_T3L, P_T4H, P_T4L} ph_t;
   typedef struct packed {
      ph_t         ph;
      logic [1:0]  op;
      logic [15:0] adr;
      logic [7:0]  dat;
      int          samp;   // index of the ready sample taken at the end of this clk, -1 if none
      int          k;      // number of ready=0 samples before ready=1
      logic        err;
      logic        last;
   } ent_t;

   ent_t        q[$];
   ent_t        cur;
   int          vec = 0;
   int          errs = 0;
   int          cyc = 0;
   logic [15:0] adr_m = 16'h0000;
   logic [6:0]  r_m = 7'd0;
   logic [7:0]  rsp_m = 8'h00;
   logic [7:0]  cap_m = 8'h00;
   logic        rsp_known = 1'b0;
   logic        din_fix = 1'b0;
   logic [7:0]  din_val = 8'h00;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      vec++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: dut=%0h want=%0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic ent_t idle_ent(input logic [15:0] a);
      ent_t e;
      e.ph = P_IDLE; e.op = OP_RD; e.adr = a; e.dat = 8'h00;
      e.samp = -1; e.k = 0; e.err = 1'b0; e.last = 1'b0;
      return e;
   endfunction

   // {mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, data_oe} required in phase p of operation op
   function automatic logic [6:0] exp_strb(input ph_t p, input logic [1:0] op);
      logic mreq, iorq, rd, wr, m1, rfsh, oe, busy, wrw;
      busy = p inside {P_T1L, P_T2H, P_T2L, P_TWH, P_TWL, P_T3H};
      wrw  = p inside {P_T2L, P_TWH, P_TWL, P_T3H};
      mreq = 1'b0; iorq = 1'b0; rd = 1'b0; wr = 1'b0; m1 = 1'b0; rfsh = 1'b0; oe = 1'b0;
      case (op)
         OP_RD: begin mreq = busy; rd = busy; end
         OP_WR: begin mreq = busy; wr = wrw; oe = busy || p == P_T3L; end
         OP_IO: begin iorq = wrw || p == P_T2H; wr = iorq; oe = busy || p == P_T3L; end
         default: begin
            m1   = p inside {P_T1H, P_T1L, P_T2H, P_T2L, P_TWH, P_TWL};
            rd   = busy && p != P_T3H;
            mreq = rd || p == P_T3L || p == P_T4H;
            rfsh = p inside {P_T3H, P_T3L, P_T4H, P_T4L};
         end
      endcase
      return {~mreq, ~iorq, ~rd, ~wr, ~m1, ~rfsh, oe};
   endfunction

   // One clk: compare the DUT against the model, then drive data_in/ready/cmd for the next edge.
   task automatic tick();
      logic [6:0] es;
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) cur = q.pop_front();
      else cur = idle_ent(adr_m);
      adr_m = cur.adr;
      if (cur.last && (cur.op == OP_RD || cur.op == OP_M1)) begin
         rsp_m = cap_m;
         rsp_known = 1'b1;
      end
      es = exp_strb(cur.ph, cur.op);
      chk("strobes", 32'({mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, data_oe}), 32'(es));
      chk("cpu_clk", 32'(cpu_clk), 32'(cur.ph inside {P_T1H, P_T2H, P_TWH, P_T3H, P_T4H}));
      chk("adr", 32'(adr), 32'(adr_m));
      chk("cmd_ready", 32'(cmd_ready), 32'(cur.ph == P_IDLE || cur.last));
      chk("rsp_valid", 32'(rsp_valid), 32'(cur.last));
      chk("rsp_err", 32'(rsp_err), 32'(cur.last && cur.err));
      if (rsp_known) chk("rsp_data", 32'(rsp_data), 32'(rsp_m));
      if (es[0]) chk("data_out", 32'(data_out), 32'(cur.dat));
      data_in = din_fix ? din_val : 8'($urandom);
      if (cur.ph == P_T3H) cap_m = data_in;
      if (cur.samp >= 0) ready = (cur.samp < cur.k) ? 1'b0 : 1'b1;
      else ready = 1'($urandom);
      if (cur.ph == P_IDLE || cur.last) begin
         cmd_valid = 1'b0;
      end else begin
         // requests while busy must be ignored
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_op    = 2'($urandom);
         cmd_adr   = 16'($urandom);
         cmd_data  = 8'($urandom);
      end
   endtask

   task automatic push_ph(input ent_t e, input ph_t p, input int s);
      ent_t x;
      x = e; x.ph = p; x.samp = s;
      q.push_back(x);
   endtask

   // Present a command now (model assumes it is accepted at the coming edge).
   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] hi, input int k);
      int          w;
      ent_t        e;
      logic [15:0] ra;
      w  = (op == OP_IO ? 1 : 0) + (k > MAX_WAIT ? MAX_WAIT : k);
      ra = {hi, 1'b0, r_m};
      if (op == OP_M1) r_m = r_m + 7'd1;
      e = idle_ent(a);
      e.op = op; e.dat = d; e.k = k; e.err = (k > MAX_WAIT);
      push_ph(e, P_T1H, -1);
      push_ph(e, P_T1L, -1);
      push_ph(e, P_T2H, -1);
      push_ph(e, P_T2L, (op == OP_IO) ? -1 : 0);
      for (int j = 0; j < w; j++) begin
         push_ph(e, P_TWH, -1);
         push_ph(e, P_TWL, (op == OP_IO) ? j : j + 1);
      end
      if (op == OP_M1) begin
         e.adr = ra;
         push_ph(e, P_T3H, -1);
         push_ph(e, P_T3L, -1);
         push_ph(e, P_T4H, -1);
         e.last = 1'b1;
         push_ph(e, P_T4L, -1);
      end else begin
         push_ph(e, P_T3H, -1);
         e.last = 1'b1;
         push_ph(e, P_T3L, -1);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_adr = a; cmd_data = d; rfsh_hi = hi;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      cmd_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         chk("rst_strobes", 32'({mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, data_oe}), 32'h7E);
         chk("rst_adr", 32'(adr), 32'h0);
         chk("rst_data_out", 32'(data_out), 32'h0);
         chk("rst_cpu_clk", 32'(cpu_clk), 32'h0);
         chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      end
      q.delete();
      adr_m = 16'h0000; r_m = 7'd0; rsp_known = 1'b0; cap_m = 8'h00;
      cur = idle_ent(16'h0000);
      reset = 1'b0;
      #1;
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
   endtask

   // Issue one command and follow it until the DUT's rsp_valid, measuring latency in clk.
   task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] hi, input int k, output int lat, output logic [7:0] rdat,
                          output logic err, output logic [15:0] fadr, output logic [15:0] radr);
      logic seen;
      seen = 1'b0; lat = 0; rdat = 8'h00; err = 1'b0; fadr = 16'h0000; radr = 16'h0000;
      issue(op, a, d, hi, k);
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (i == 1) fadr = adr;
         if (!rfsh_b && !seen) begin radr = adr; seen = 1'b1; end
         if (rsp_valid) begin
            lat = i; rdat = rsp_data; err = rsp_err;
            break;
         end
      end
      if (lat == 0) begin
         vec++;
         errs++;
         $display("FAIL rsp_wait_bound: no rsp_valid within 100 clk (cycle %0d)", cyc);
      end
   endtask

   initial begin
      int          lat;
      logic [7:0]  rd;
      logic        er;
      logic [15:0] fa, ra;
      do_reset(2);

      din_fix = 1'b1; din_val = 8'hA5;
      run_cmd(OP_RD, 16'h4000, 8'h00, 8'h00, 0, lat, rd, er, fa, ra);
      chk("rd_latency", 32'(lat), 32'd6);
      chk("rd_data", 32'(rd), 32'hA5);
      chk("rd_err", 32'(er), 32'h0);
      din_fix = 1'b0;

      run_cmd(OP_IO, 16'h7FFF, 8'hC4, 8'h00, 0, lat, rd, er, fa, ra);
      chk("io_latency", 32'(lat), 32'd8);

      run_cmd(OP_M1, 16'h0100, 8'h00, 8'h3F, 0, lat, rd, er, fa, ra);
      chk("m1_latency", 32'(lat), 32'd8);
      chk("m1_rfsh_adr_r0", 32'(ra), 32'h3F00);
      run_cmd(OP_WR, 16'h8123, 8'h5A, 8'h00, 0, lat, rd, er, fa, ra);
      chk("b2b_wr_t1h_adr", 32'(fa), 32'h8123);
      chk("wr_latency", 32'(lat), 32'd6);

      run_cmd(OP_M1, 16'h1234, 8'h00, 8'h3F, 0, lat, rd, er, fa, ra);
      chk("m1_rfsh_adr_r1", 32'(ra), 32'h3F01);

      run_cmd(OP_WR, 16'hC000, 8'h33, 8'h00, 3, lat, rd, er, fa, ra);
      chk("wr_3wait_latency", 32'(lat), 32'd12);
      chk("wr_3wait_err", 32'(er), 32'h0);

      run_cmd(OP_WR, 16'hC001, 8'h44, 8'h00, MAX_WAIT + 1, lat, rd, er, fa, ra);
      chk("wr_timeout_latency", 32'(lat), 32'd36);
      chk("wr_timeout_err", 32'(er), 32'h1);

      run_cmd(OP_IO, 16'h7F00, 8'hC1, 8'h00, MAX_WAIT + 1, lat, rd, er, fa, ra);
      chk("io_timeout_latency", 32'(lat), 32'd38);
      chk("io_timeout_err", 32'(er), 32'h1);

      // reset while a write sits in T2L
      issue(OP_WR, 16'hBEEF, 8'h77, 8'h00, 0);
      repeat (4) tick();
      do_reset(1);
      repeat (3) tick();

      for (int n = 0; n < 3000; n++) begin
         tick();
         if ((cur.ph == P_IDLE || cur.last) && $urandom_range(0, 3) != 0) begin
            int sel, kk;
            sel = int'($urandom_range(0, 9));
            if (sel <= 5) kk = 0;
            else if (sel <= 8) kk = int'($urandom_range(1, MAX_WAIT));
            else kk = MAX_WAIT + 1;
            issue(2'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), kk);
         end
      end
      for (int i = 0; i < 80 && (q.size() > 0 || cur.last); i++) tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #400000;
      errs++;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cpc_bus_initiator.md
# cpc_bus_initiator

Z80-style bus cycle generator that drives the CPC expansion-bus signals seen by the RAM expansion CPLD: memory read, memory write, opcode fetch with refresh, and I/O write cycles (e.g. bank-select writes of 0b11cccbbb to &7Fxx/&7Exx). It sits between a command source (bench sequencer or soft CPU) and the bus pins. It produces cycle-accurate strobe sequencing at half-T-state resolution and honours READY wait states.

## Interface
- MAX_WAIT, 15: maximum consecutive TW states before forced completion with error.
- clk  in  1  system clock, 2x CPU clock; one clk = one half T-state.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on clk edge where valid&ready.
- cmd_op  in  2  00 mem read, 01 mem write, 10 I/O write, 11 opcode fetch (M1).
- cmd_adr  in  16  cycle address.
- cmd_data  in  8  write data.
- rfsh_hi  in  8  upper refresh address byte (I register).
- rsp_valid  out  1  one-clk pulse per completed command.
- rsp_data  out  8  read/fetch data; held until next rsp_valid.
- rsp_err  out  1  valid with rsp_valid; 1 = wait timeout.
- cpu_clk  out  1  1 in H halves, 0 in L halves and idle.
- adr  out  16  address bus.
- data_out  out  8  data driven to bus; data_oe  out  1  drive enable.
- data_in  in  8  bus data.
- ready  in  1  wait request, 0 = wait.
- mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b  out  1 each  active-low strobes.

## Operation
- States: IDLE, T1H, T1L, T2H, T2L, TWH, TWL, T3H, T3L, T4H, T4L.
- IDLE: all strobes 1, data_oe 0, adr holds last value, cmd_ready 1. Accept -> T1H; command fields latched.
- Mem read: T1H adr valid; T1L mreq_b=0, rd_b=0; end of T2L sample ready; T3H data_in captured at end of T3H; T3L mreq_b=rd_b=1, rsp_valid.
- Mem write: T1L mreq_b=0, data_oe=1; T2L wr_b=0; T3L mreq_b=wr_b=1; data_oe drops on exit from T3L.
- I/O write: T1L data_oe=1; T2H iorq_b=0, wr_b=0; one TW always inserted; ready sampled at end of TWL; T3L iorq_b=wr_b=1.
- Opcode fetch: T1H m1_b=0; T1L mreq_b=rd_b=0; ready at end of T2L; end of T3H data captured; T3H m1_b=rd_b=mreq_b=1, rfsh_b=0, adr={rfsh_hi, r}; T3L,T4H mreq_b=0; T4L mreq_b=1, rfsh_b=0, rsp_valid; rfsh_b=1 on exit. r[6:0] increments per fetch, r[7] constant 0; reset 0.
- Wait: ready=0 at sampling edge -> TWH/TWL, resample at end of each TWL. After MAX_WAIT TWs (excluding the automatic I/O TW) proceed to T3H and set rsp_err.
- cmd_ready also 1 in final state (T3L or T4L); accept there -> T1H directly, no idle gap.
- rsp_data for writes: unchanged.

## Timing
- Reset: state IDLE, all strobes 1, adr 0, data_out 0, data_oe 0, cpu_clk 0, cmd_ready 0 during reset then 1, rsp_valid 0, rsp_err 0, r 0.
- Reset mid-cycle: next edge returns to reset values; no rsp_valid for aborted command.
- Zero-wait latency accept -> rsp_valid: read/write 6 clk, I/O 8 clk, fetch 8 clk.
- Each TW adds 2 clk. Strobes registered; no combinational path from cmd_* to bus pins.
- ready ignored outside sampling edges.

## Test plan
- Reset mid-T2L of a mem write -> next clk mreq_b=wr_b=1, data_oe=0, no rsp_valid, cmd_ready=1 after reset.
- Mem read adr=&4000, data_in=&A5, ready=1 -> mreq_b/rd_b low T1L..T3H, rsp_valid 6 clk after accept, rsp_data=&A5, rsp_err=0.
- I/O write adr=&7FFF data=&C4, ready=1 -> iorq_b/wr_b low from T2H through TWL, data_oe T1L..T3L, rsp_valid at clk 8.
- Back-to-back fetch then mem write, ready=1 -> rfsh_b low T3H..T4L, adr={rfsh_hi,r}, r increments 0->1, write T1H immediately after T4L.
- Mem write with ready=0 for 3 samples -> exactly 3 TW pairs, wr_b held low, rsp_valid at clk 12.
- ready stuck 0, MAX_WAIT=15 -> 15 TWs then completion with rsp_err=1, strobes released in T3L.
